// File: rtl/video_timing_gen.sv
// Video timing generator: free-running pixel/line counters with registered
// sync, active-draw, new-frame and frame-counter outputs.
module video_timing_gen #(
    parameter int ACTIVE_H = 1280,
    parameter int H_FP     = 110,
    parameter int H_SYNC   = 40,
    parameter int H_BP     = 220,
    parameter int ACTIVE_V = 720,
    parameter int V_FP     = 5,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 20,
    parameter int FPS      = 60
) (
    input  logic        clk_in,
    input  logic        rst_in,
    output logic [10:0] h_count_out,
    output logic [9:0]  v_count_out,
    output logic        hs_out,
    output logic        vs_out,
    output logic        ad_out,
    output logic [1:0]  control_out,
    output logic        nf_out,
    output logic [5:0]  fc_out
);

    localparam int H_TOTAL = ACTIVE_H + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = ACTIVE_V + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [10:0] H_ACT    = 11'(ACTIVE_H);
    localparam logic [9:0]  V_ACT    = 10'(ACTIVE_V);
    localparam logic [10:0] HS_START = 11'(ACTIVE_H + H_FP);
    localparam logic [10:0] HS_END   = 11'(ACTIVE_H + H_FP + H_SYNC);
    localparam logic [9:0]  VS_START = 10'(ACTIVE_V + V_FP);
    localparam logic [9:0]  VS_END   = 10'(ACTIVE_V + V_FP + V_SYNC);
    localparam logic [5:0]  FC_LAST  = 6'(FPS - 1);

    // ST_IDLE marks the first edge after reset, which loads (0,0) instead of
    // incrementing so that position (0,0) is presented right after release.
    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [10:0] h_next;
    logic [9:0]  v_next;
    logic [5:0]  fc_next;
    logic        nf_next;
    logic        ad_next;
    logic        hs_next;
    logic        vs_next;

    // State register: leave idle on the first edge with reset low
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next position, frame counter and decode of the next position
    always_comb begin
        state_next = ST_RUN;
        h_next     = '0;
        v_next     = '0;
        fc_next    = fc_out;
        nf_next    = 1'b0;

        if (state == ST_RUN) begin
            if (h_count_out == H_LAST) begin
                h_next = '0;
                v_next = (v_count_out == V_LAST) ? '0 : v_count_out + 10'd1;
            end else begin
                h_next = h_count_out + 11'd1;
                v_next = v_count_out;
            end
        end

        nf_next = (h_next == H_ACT) && (v_next == V_ACT);
        if (nf_next) begin
            fc_next = (fc_out == FC_LAST) ? '0 : fc_out + 6'd1;
        end

        ad_next = (h_next < H_ACT) && (v_next < V_ACT);
        hs_next = (h_next >= HS_START) && (h_next < HS_END);
        vs_next = (v_next >= VS_START) && (v_next < VS_END);
    end

    // Output registers: decode is computed from the next counts so every
    // output matches the counts presented in the same cycle
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            h_count_out <= '0;
            v_count_out <= '0;
            hs_out      <= 1'b0;
            vs_out      <= 1'b0;
            ad_out      <= 1'b0;
            control_out <= '0;
            nf_out      <= 1'b0;
            fc_out      <= '0;
        end else begin
            h_count_out <= h_next;
            v_count_out <= v_next;
            hs_out      <= hs_next;
            vs_out      <= vs_next;
            ad_out      <= ad_next;
            control_out <= {vs_next, hs_next};
            nf_out      <= nf_next;
            fc_out      <= fc_next;
        end
    end

endmodule

// File: tb/tb_video_timing_gen.sv
// Self-checking bench for video_timing_gen: default, medium and tiny
// parameter sets, each checked cycle by cycle against a behavioural model.
module tb_video_timing_gen;

    typedef struct packed {
        logic [10:0] h;
        logic [9:0]  v;
        logic        hs;
        logic        vs;
        logic        ad;
        logic [1:0]  ctl;
        logic        nf;
        logic [5:0]  fc;
    } obs_t;

    logic clk = 1'b0;
    logic rst0 = 1'b1, rst1 = 1'b1, rst2 = 1'b1;

    logic [10:0] h0, h1, h2;
    logic [9:0]  v0, v1, v2;
    logic        hs0, hs1, hs2, vs0, vs1, vs2, ad0, ad1, ad2, nf0, nf1, nf2;
    logic [1:0]  ctl0, ctl1, ctl2;
    logic [5:0]  fc0, fc1, fc2;

    // Configurations: 0 = default 720p, 1 = medium, 2 = tiny
    int c_ah[3]  = '{1280, 16, 4};
    int c_hfp[3] = '{110, 3, 1};
    int c_hsy[3] = '{40, 4, 2};
    int c_hbp[3] = '{220, 5, 1};
    int c_av[3]  = '{720, 10, 2};
    int c_vfp[3] = '{5, 2, 1};
    int c_vsy[3] = '{5, 3, 1};
    int c_vbp[3] = '{20, 2, 1};
    int c_fps[3] = '{60, 60, 3};

    int mh[3], mv[3], mfc[3];
    bit mrun[3];

    obs_t exp_q[$];
    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    video_timing_gen u_dut0 (
        .clk_in(clk), .rst_in(rst0), .h_count_out(h0), .v_count_out(v0),
        .hs_out(hs0), .vs_out(vs0), .ad_out(ad0), .control_out(ctl0),
        .nf_out(nf0), .fc_out(fc0)
    );

    video_timing_gen #(
        .ACTIVE_H(16), .H_FP(3), .H_SYNC(4), .H_BP(5),
        .ACTIVE_V(10), .V_FP(2), .V_SYNC(3), .V_BP(2), .FPS(60)
    ) u_dut1 (
        .clk_in(clk), .rst_in(rst1), .h_count_out(h1), .v_count_out(v1),
        .hs_out(hs1), .vs_out(vs1), .ad_out(ad1), .control_out(ctl1),
        .nf_out(nf1), .fc_out(fc1)
    );

    video_timing_gen #(
        .ACTIVE_H(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .ACTIVE_V(2), .V_FP(1), .V_SYNC(1), .V_BP(1), .FPS(3)
    ) u_dut2 (
        .clk_in(clk), .rst_in(rst2), .h_count_out(h2), .v_count_out(v2),
        .hs_out(hs2), .vs_out(vs2), .ad_out(ad2), .control_out(ctl2),
        .nf_out(nf2), .fc_out(fc2)
    );

    function automatic string fmt(obs_t o);
        return $sformatf("h=%0d v=%0d hs=%b vs=%b ad=%b ctl=%b nf=%b fc=%0d",
                         o.h, o.v, o.hs, o.vs, o.ad, o.ctl, o.nf, o.fc);
    endfunction

    function automatic obs_t sample(int i);
        case (i)
            0:       return {h0, v0, hs0, vs0, ad0, ctl0, nf0, fc0};
            1:       return {h1, v1, hs1, vs1, ad1, ctl1, nf1, fc1};
            default: return {h2, v2, hs2, vs2, ad2, ctl2, nf2, fc2};
        endcase
    endfunction

    // Advance the model of instance i by one edge and queue its expectation
    task automatic model_step(input int i, input logic rst);
        obs_t e;
        int   htot, vtot, hs0p, vs0p;
        e = '0;
        if (rst) begin
            mrun[i] = 0; mh[i] = 0; mv[i] = 0; mfc[i] = 0;
        end else begin
            htot = c_ah[i] + c_hfp[i] + c_hsy[i] + c_hbp[i];
            vtot = c_av[i] + c_vfp[i] + c_vsy[i] + c_vbp[i];
            if (!mrun[i]) begin
                mrun[i] = 1; mh[i] = 0; mv[i] = 0;
            end else begin
                mh[i]++;
                if (mh[i] == htot) begin
                    mh[i] = 0;
                    mv[i]++;
                    if (mv[i] == vtot) mv[i] = 0;
                end
            end
            if (mh[i] == c_ah[i] && mv[i] == c_av[i]) begin
                e.nf = 1'b1;
                mfc[i] = (mfc[i] + 1) % c_fps[i];
            end
            hs0p = c_ah[i] + c_hfp[i];
            vs0p = c_av[i] + c_vfp[i];
            e.h  = 11'(mh[i]);
            e.v  = 10'(mv[i]);
            e.ad = (mh[i] < c_ah[i]) && (mv[i] < c_av[i]);
            e.hs = (mh[i] >= hs0p) && (mh[i] < hs0p + c_hsy[i]);
            e.vs = (mv[i] >= vs0p) && (mv[i] < vs0p + c_vsy[i]);
            e.ctl = {e.vs, e.hs};
            e.fc = 6'(mfc[i]);
        end
        exp_q.push_back(e);
    endtask

    // Drive reset for instance i, clock once, return expected and observed
    task automatic advance(input int i, input logic rst, output obs_t e, output obs_t a);
        case (i)
            0:       rst0 = rst;
            1:       rst1 = rst;
            default: rst2 = rst;
        endcase
        model_step(i, rst);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        a = sample(i);
    endtask

    task automatic test_reset();
        obs_t e, a;
        for (int c = 0; c < 3; c++) begin
            advance(0, 1'b1, e, a);
            checks++;
            if (a !== e) $display("FAIL reset_hold: got %s want %s", fmt(a), fmt(e));
            else passed++;
        end
        advance(0, 1'b0, e, a);
        checks++;
        if (a !== e) $display("FAIL first_run: got %s want %s", fmt(a), fmt(e));
        else passed++;
        checks++;
        if (a.h !== 11'd0 || a.v !== 10'd0 || a.ad !== 1'b1 || a.hs !== 1'b0 ||
            a.vs !== 1'b0 || a.nf !== 1'b0 || a.fc !== 6'd0)
            $display("FAIL first_run_const: got %s want h=0 v=0 ad=1 hs=0 vs=0 nf=0 fc=0", fmt(a));
        else passed++;
        advance(0, 1'b0, e, a);
        checks++;
        if (a !== e || a.h !== 11'd1) $display("FAIL second_run: got %s want %s", fmt(a), fmt(e));
        else passed++;
    endtask

    // Continues from h=1 of line 0 on the default instance
    task automatic test_line();
        obs_t e, a;
        int ad_cnt = 2, hs_cnt = 0, hs_first = -1, prev_h = 1;
        for (int c = 0; c < 1649; c++) begin
            advance(0, 1'b0, e, a);
            checks++;
            if (a !== e) $display("FAIL line_cycle: got %s want %s", fmt(a), fmt(e));
            else passed++;
            if (a.v == 10'd0) begin
                prev_h = int'(a.h);
                if (a.ad) ad_cnt++;
                if (a.hs) begin
                    hs_cnt++;
                    if (hs_first < 0) hs_first = int'(a.h);
                end
            end
        end
        checks++;
        if (a.h !== 11'd0 || a.v !== 10'd1 || prev_h != 1649)
            $display("FAIL line_wrap: got h=%0d v=%0d last_h=%0d want h=0 v=1 last_h=1649", a.h, a.v, prev_h);
        else passed++;
        checks++;
        if (ad_cnt != 1280) $display("FAIL line_ad_count: got %0d want 1280", ad_cnt);
        else passed++;
        checks++;
        if (hs_cnt != 40 || hs_first != 1390)
            $display("FAIL line_hs: got count=%0d first=%0d want count=40 first=1390", hs_cnt, hs_first);
        else passed++;
    endtask

    // Medium instance: H_TOTAL=28, V_TOTAL=17, vsync lines 12..14
    task automatic test_frame();
        obs_t e, a;
        int vs_cnt = 0, nf_cnt = 0, wraps = 0, nf_h = -1, nf_v = -1, nf_fc = -1;
        bit at_end = 0;
        for (int c = 0; c < 3; c++) begin
            advance(1, 1'b1, e, a);
            checks++;
            if (a !== e) $display("FAIL frame_reset: got %s want %s", fmt(a), fmt(e));
            else passed++;
        end
        for (int c = 0; c < 2 * 476 + 1; c++) begin
            advance(1, 1'b0, e, a);
            checks++;
            if (a !== e) $display("FAIL frame_cycle: got %s want %s", fmt(a), fmt(e));
            else passed++;
            if (at_end) begin
                wraps++;
                checks++;
                if (a.h !== 11'd0 || a.v !== 10'd0)
                    $display("FAIL frame_wrap: got h=%0d v=%0d want h=0 v=0", a.h, a.v);
                else passed++;
            end
            at_end = (a.h == 11'd27 && a.v == 10'd16);
            if (c < 476) begin
                if (a.vs) vs_cnt++;
                if (a.nf) begin
                    nf_cnt++; nf_h = int'(a.h); nf_v = int'(a.v); nf_fc = int'(a.fc);
                end
            end
        end
        checks++;
        if (vs_cnt != 84) $display("FAIL frame_vs_count: got %0d want 84", vs_cnt);
        else passed++;
        checks++;
        if (nf_cnt != 1 || nf_h != 16 || nf_v != 10 || nf_fc != 1)
            $display("FAIL frame_nf: got n=%0d h=%0d v=%0d fc=%0d want n=1 h=16 v=10 fc=1",
                     nf_cnt, nf_h, nf_v, nf_fc);
        else passed++;
        checks++;
        if (wraps != 2) $display("FAIL frame_wrap_count: got %0d want 2", wraps);
        else passed++;
    endtask

    task automatic test_fps();
        obs_t e, a;
        int k = 0, last = 0;
        for (int c = 0; c < 2; c++) advance(1, 1'b1, e, a);
        for (int c = 0; c < 28400; c++) begin
            advance(1, 1'b0, e, a);
            checks++;
            if (a !== e) $display("FAIL fps_cycle: got %s want %s", fmt(a), fmt(e));
            else passed++;
            if (a.nf) begin
                k++;
                checks++;
                if (a.fc !== 6'(k % 60)) $display("FAIL fps_fc: pulse %0d got fc=%0d want %0d", k, a.fc, k % 60);
                else passed++;
                checks++;
                if ((k == 1 && c != 296) || (k > 1 && c - last != 476))
                    $display("FAIL fps_spacing: pulse %0d at cycle %0d, previous %0d", k, c, last);
                else passed++;
                last = c;
            end
        end
        checks++;
        if (k != 60) $display("FAIL fps_pulse_count: got %0d want 60", k);
        else passed++;
    endtask

    task automatic test_midframe_reset();
        obs_t e, a;
        bit found = 0;
        for (int c = 0; c < 2; c++) advance(1, 1'b1, e, a);
        for (int c = 0; c < 3000 && !found; c++) begin
            advance(1, 1'b0, e, a);
            checks++;
            if (a !== e) $display("FAIL mid_cycle: got %s want %s", fmt(a), fmt(e));
            else passed++;
            found = (a.fc == 6'd3 && a.h == 11'd12 && a.v == 10'd8);
        end
        checks++;
        if (!found) $display("FAIL mid_reach: got %s want h=12 v=8 fc=3 within 3000 cycles", fmt(a));
        else passed++;
        advance(1, 1'b1, e, a);
        checks++;
        if (a !== '0 || a !== e) $display("FAIL mid_reset: got %s want %s", fmt(a), fmt(e));
        else passed++;
        advance(1, 1'b0, e, a);
        checks++;
        if (a !== e || a.h !== 11'd0 || a.v !== 10'd0 || a.fc !== 6'd0 || a.ad !== 1'b1)
            $display("FAIL mid_restart: got %s want %s", fmt(a), fmt(e));
        else passed++;
        for (int c = 0; c < 30; c++) begin
            advance(1, 1'b0, e, a);
            checks++;
            if (a !== e) $display("FAIL mid_resume: got %s want %s", fmt(a), fmt(e));
            else passed++;
        end
    endtask

    // Tiny instance: H_TOTAL=8, V_TOTAL=5, FPS=3
    task automatic test_small();
        obs_t e, a;
        int hmax = 0, vmax = 0, k = 0;
        for (int c = 0; c < 3; c++) advance(2, 1'b1, e, a);
        for (int c = 0; c < 130; c++) begin
            advance(2, 1'b0, e, a);
            checks++;
            if (a !== e) $display("FAIL small_cycle: got %s want %s", fmt(a), fmt(e));
            else passed++;
            if (int'(a.h) > hmax) hmax = int'(a.h);
            if (int'(a.v) > vmax) vmax = int'(a.v);
            if (a.nf) begin
                k++;
                checks++;
                if (a.fc !== 6'(k % 3)) $display("FAIL small_fc: pulse %0d got fc=%0d want %0d", k, a.fc, k % 3);
                else passed++;
            end
        end
        checks++;
        if (hmax != 7 || vmax != 4) $display("FAIL small_totals: got hmax=%0d vmax=%0d want 7 4", hmax, vmax);
        else passed++;
        checks++;
        if (k < 3) $display("FAIL small_nf_count: got %0d want at least 3", k);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_line();
        test_frame();
        test_fps();
        test_midframe_reset();
        test_small();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/video_timing_gen.md
VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 SHALL have parameter ACTIVE_H, default 1280, active pixels per line.
REQ-002 SHALL have parameter H_FP, default 110, horizontal front porch in pixels.
REQ-003 SHALL have parameter H_SYNC, default 40, hsync width in pixels.
REQ-004 SHALL have parameter H_BP, default 220, horizontal back porch in pixels.
REQ-005 SHALL have parameter ACTIVE_V, default 720, active lines per frame.
REQ-006 SHALL have parameter V_FP, default 5, vertical front porch in lines.
REQ-007 SHALL have parameter V_SYNC, default 5, vsync width in lines.
REQ-008 SHALL have parameter V_BP, default 20, vertical back porch in lines.
REQ-009 SHALL have parameter FPS, default 60, frame-counter modulus.
REQ-010 SHALL use one clock; reset is synchronous and active-high: clk_in, rst_in.
REQ-011 SHALL have port clk_in  input  1  pixel clock; all state on rising edge.
REQ-012 SHALL have port rst_in  input  1  synchronous active-high reset.
REQ-013 SHALL have port h_count_out  output  11  current pixel column, 0..H_TOTAL-1.
REQ-014 SHALL have port v_count_out  output  10  current line, 0..V_TOTAL-1.
REQ-015 SHALL have port hs_out  output  1  horizontal sync, active high.
REQ-016 SHALL have port vs_out  output  1  vertical sync, active high.
REQ-017 SHALL have port ad_out  output  1  active draw; drives encoder video-enable.
REQ-018 SHALL have port control_out  output  2  {vs_out, hs_out}; drives blue-channel encoder control.
REQ-019 SHALL have port nf_out  output  1  one-cycle new-frame pulse.
REQ-020 SHALL have port fc_out  output  6  frame counter, 0..FPS-1.

Function
REQ-021 SHALL define H_TOTAL = ACTIVE_H+H_FP+H_SYNC+H_BP (1650 default) and V_TOTAL = ACTIVE_V+V_FP+V_SYNC+V_BP (750 default).
REQ-022 SHALL increment h_count_out every cycle; at H_TOTAL-1 it wraps to 0 and v_count_out advances by 1.
REQ-023 SHALL wrap v_count_out from V_TOTAL-1 to 0 on the same edge h_count_out wraps, i.e. (1649,749) -> (0,0).
REQ-024 SHALL register all outputs so every output in a given cycle is the decode of the h/v counts presented in that same cycle; no output is combinational from inputs.
REQ-025 SHALL assert ad_out iff h_count_out < ACTIVE_H and v_count_out < ACTIVE_V.
REQ-026 SHALL assert hs_out iff ACTIVE_H+H_FP <= h_count_out < ACTIVE_H+H_FP+H_SYNC (1390..1429 default), on every line including vertical blanking.
REQ-027 SHALL assert vs_out iff ACTIVE_V+V_FP <= v_count_out < ACTIVE_V+V_FP+V_SYNC (725..729 default), for all columns of those lines.
REQ-028 SHALL keep control_out equal to {vs_out, hs_out} in every cycle.
REQ-029 SHALL assert nf_out for exactly one cycle, the cycle with h_count_out==ACTIVE_H and v_count_out==ACTIVE_V; low otherwise.
REQ-030 SHALL update fc_out on the edge that asserts nf_out, so fc_out already holds the new value in the nf_out cycle; FPS-1 wraps to 0.
REQ-031 SHALL free-run with no stall input; sequence depends only on cycles since reset release.
REQ-032 SHALL use widths sufficient for parameter values up to 2047 columns and 1023 lines; wider configurations are out of scope.

Reset
REQ-033 SHALL, in any cycle with rst_in high, drive h_count_out=0, v_count_out=0, hs_out=0, vs_out=0, ad_out=0, control_out=2'b00, nf_out=0, fc_out=0.
REQ-034 SHALL, on the first edge with rst_in low, present (0,0) with ad_out=1 and all other outputs at their decoded values; fc_out=0.
REQ-035 SHALL abandon any frame in progress when rst_in asserts mid-frame and restart from (0,0) with fc_out=0; no nf_out pulse is generated by reset.

Verification
REQ-036 SHALL cover: reset held 3 cycles, released -> first cycle h=0, v=0, ad=1, hs=0, vs=0, nf=0, fc=0; next cycle h=1.
REQ-037 SHALL cover: run one line -> ad high h=0..1279, low h=1280..1649; hs high exactly h=1390..1429 (40 cycles); h wraps 1649->0 with v 0->1.
REQ-038 SHALL cover: run full frame -> vs high exactly for v=725..729 (5 x 1650 cycles); nf single pulse at (1280,720) with fc 0->1 that cycle; (1649,749)->(0,0).
REQ-039 SHALL cover: run 60 frames -> fc sequence 0..59 then 0 at the 60th nf pulse; 60 nf pulses spaced 1,237,500 cycles.
REQ-040 SHALL cover: assert rst_in at (700,400) with fc=3 -> outputs at reset values next cycle; after release counting resumes at (0,0), fc=0.
REQ-041 SHALL cover: small parameter set (ACTIVE_H=4, H_FP=1, H_SYNC=2, H_BP=1, ACTIVE_V=2, V_FP=1, V_SYNC=1, V_BP=1, FPS=3) -> H_TOTAL=8, V_TOTAL=5, control_out=={vs,hs} every cycle, fc wraps 2->0.
